// File: rtl/tt_ctrl_pkg.sv
// Shared types and default constants for the tt_ctrl_sel control-pad front end.
// The FSM state type and the default parameter values live here.
package tt_ctrl_pkg;

    typedef enum logic [1:0] {
        SELECT = 2'd0,
        SETTLE = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam int TT_ADDR_W      = 10;
    localparam int TT_N_DESIGNS   = 1024;
    localparam int TT_SYNC_STAGES = 2;
    localparam int TT_SETTLE_CYC  = 4;
    localparam int TT_DEB_CYC     = 8;

endpackage

// File: rtl/tt_ctrl_sync.sv
// Pad input synchroniser (STAGES flops, reset to 0) with an optional debouncer
// whose output follows the input only after DEB_CYC consecutive stable samples.
module tt_ctrl_sync
    import tt_ctrl_pkg::*;
#(
    parameter int STAGES  = TT_SYNC_STAGES,
    parameter bit DEB_EN  = 1'b0,
    parameter int DEB_CYC = TT_DEB_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    generate
        if (DEB_EN) begin : g_deb
            localparam int CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

            logic [CNT_W-1:0] cnt;
            logic             stable;

            // cnt counts consecutive samples that disagree with the current output.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt    <= '0;
                    stable <= 1'b0;
                end else if (chain[STAGES-1] == stable) begin
                    cnt <= '0;
                end else if (cnt == CNT_W'(DEB_CYC - 1)) begin
                    stable <= chain[STAGES-1];
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end

            assign q = stable;
        end else begin : g_pass
            assign q = chain[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/tt_ctrl_sel.sv
// Control-pad front end: synchronises the pads, counts select pulses into an
// address and hands the enable over only after a settle window.
// Optional debouncing of inc/ena is compiled in with `define TT_CTRL_DEBOUNCE_EN.
module tt_ctrl_sel
    import tt_ctrl_pkg::*;
#(
    parameter int ADDR_W      = TT_ADDR_W,
    parameter int N_DESIGNS   = TT_N_DESIGNS,
    parameter int SYNC_STAGES = TT_SYNC_STAGES,
    parameter int SETTLE_CYC  = TT_SETTLE_CYC,
    parameter int DEB_CYC     = TT_DEB_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pad_sel_rst_n,
    input  logic              pad_sel_inc,
    input  logic              pad_ena,
    output logic [ADDR_W-1:0] sel_addr,
    output logic              sel_ena,
    output logic              sel_busy,
    output logic              sel_ovf
);

`ifdef TT_CTRL_DEBOUNCE_EN
    localparam bit DEB_EN = 1'b1;
`else
    localparam bit DEB_EN = 1'b0;
`endif

    localparam int                CNT_W     = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_DESIGNS - 1);

    logic s_rst_n;
    logic s_inc;
    logic s_ena;
    logic s_inc_d;
    logic inc_rise;

    state_t            state;
    state_t            state_nx;
    logic [CNT_W-1:0]  settle_cnt;
    logic [CNT_W-1:0]  settle_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic              ovf_nx;

    // The selection reset is never debounced so it always acts after SYNC_STAGES.
    tt_ctrl_sync #(
        .STAGES  (SYNC_STAGES),
        .DEB_EN  (1'b0),
        .DEB_CYC (DEB_CYC)
    ) u_sync_rst (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pad_sel_rst_n),
        .q     (s_rst_n)
    );

    tt_ctrl_sync #(
        .STAGES  (SYNC_STAGES),
        .DEB_EN  (DEB_EN),
        .DEB_CYC (DEB_CYC)
    ) u_sync_inc (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pad_sel_inc),
        .q     (s_inc)
    );

    tt_ctrl_sync #(
        .STAGES  (SYNC_STAGES),
        .DEB_EN  (DEB_EN),
        .DEB_CYC (DEB_CYC)
    ) u_sync_ena (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pad_ena),
        .q     (s_ena)
    );

    assign inc_rise = s_inc & ~s_inc_d;

    // NOTE: every variable gets a default at the top of always_comb, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nx  = state;
        settle_nx = settle_cnt;
        case (state)
            SELECT: begin
                if (s_rst_n && !inc_rise && s_ena) begin
                    state_nx  = SETTLE;
                    settle_nx = CNT_W'(SETTLE_CYC - 1);
                end
            end
            SETTLE: begin
                if (!s_rst_n || !s_ena) begin
                    state_nx = SELECT;
                end else if (settle_cnt == '0) begin
                    state_nx = ACTIVE;
                end else begin
                    settle_nx = settle_cnt - CNT_W'(1);
                end
            end
            ACTIVE: begin
                if (!s_rst_n || !s_ena) begin
                    state_nx = SELECT;
                end
            end
            default: state_nx = SELECT;
        endcase
    end

    // Address only moves in SELECT, so it can never change under an enabled design.
    always_comb begin
        addr_nx = sel_addr;
        ovf_nx  = sel_ovf;
        if (!s_rst_n) begin
            addr_nx = '0;
            ovf_nx  = 1'b0;
        end else if (inc_rise && (state == SELECT)) begin
            if (sel_addr == LAST_ADDR) begin
                addr_nx = '0;
                ovf_nx  = 1'b1;
            end else begin
                addr_nx = sel_addr + ADDR_W'(1);
            end
        end
    end

    // Outputs are registered from the next state so sel_ena changes on the same
    // edge the FSM enters or leaves ACTIVE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SELECT;
            settle_cnt <= '0;
            s_inc_d    <= 1'b0;
            sel_addr   <= '0;
            sel_ovf    <= 1'b0;
            sel_ena    <= 1'b0;
            sel_busy   <= 1'b1;
        end else begin
            state      <= state_nx;
            settle_cnt <= settle_nx;
            s_inc_d    <= s_inc;
            sel_addr   <= addr_nx;
            sel_ovf    <= ovf_nx;
            sel_ena    <= (state_nx == ACTIVE);
            sel_busy   <= (state_nx != ACTIVE);
        end
    end

endmodule

// File: tb/tb_tt_ctrl_sel.sv
// Self-checking bench for tt_ctrl_sel: a run-length behavioural model checked
// every cycle against a default instance and a 4-address instance.
module tb_tt_ctrl_sel;
    import tt_ctrl_pkg::*;

    localparam int SYNC    = TT_SYNC_STAGES;
    localparam int SETTLE  = TT_SETTLE_CYC;
    localparam int DEB     = 8;
`ifdef TT_CTRL_DEBOUNCE_EN
    localparam int DEB_LAT = DEB;
`else
    localparam int DEB_LAT = 0;
`endif
    localparam int PW      = 2 + DEB_LAT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pad_sel_rst_n = 1'b1;
    logic       pad_sel_inc = 1'b0;
    logic       pad_ena = 1'b0;
    logic [9:0] addr_a, addr_b;
    logic       ena_a, ena_b, busy_a, busy_b, ovf_a, ovf_b;

    always #5 clk = ~clk;

    tt_ctrl_sel #(
        .ADDR_W(10), .N_DESIGNS(1024), .SYNC_STAGES(SYNC), .SETTLE_CYC(SETTLE), .DEB_CYC(DEB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pad_sel_rst_n(pad_sel_rst_n), .pad_sel_inc(pad_sel_inc),
        .pad_ena(pad_ena), .sel_addr(addr_a), .sel_ena(ena_a), .sel_busy(busy_a), .sel_ovf(ovf_a)
    );

    tt_ctrl_sel #(
        .ADDR_W(10), .N_DESIGNS(4), .SYNC_STAGES(SYNC), .SETTLE_CYC(SETTLE), .DEB_CYC(DEB)
    ) dut_small (
        .clk(clk), .rst_n(rst_n), .pad_sel_rst_n(pad_sel_rst_n), .pad_sel_inc(pad_sel_inc),
        .pad_ena(pad_ena), .sel_addr(addr_b), .sel_ena(ena_b), .sel_busy(busy_b), .sel_ovf(ovf_b)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pad histories give the synchronised view; "run" is the number of
    // consecutive cycles enable has been requested since the last selection.
    bit p_rst[SYNC];
    bit p_inc[SYNC];
    bit p_ena[SYNC];
`ifdef TT_CTRL_DEBOUNCE_EN
    bit h_inc[DEB];
    bit h_ena[DEB];
    bit d_inc, d_ena;
`endif
    bit m_inc_d;
    int run;
    int m_addr[2];
    bit m_ovf[2];
    int n_des[2] = '{1024, 4};

    task automatic model_reset();
        for (int i = 0; i < SYNC; i++) begin
            p_rst[i] = 1'b0;
            p_inc[i] = 1'b0;
            p_ena[i] = 1'b0;
        end
`ifdef TT_CTRL_DEBOUNCE_EN
        for (int i = 0; i < DEB; i++) begin
            h_inc[i] = 1'b0;
            h_ena[i] = 1'b0;
        end
        d_inc = 1'b0;
        d_ena = 1'b0;
`endif
        m_inc_d = 1'b0;
        run = 0;
        for (int k = 0; k < 2; k++) begin
            m_addr[k] = 0;
            m_ovf[k]  = 1'b0;
        end
    endtask

    task automatic model_step();
        bit sr, si, se, rise;
        sr = p_rst[SYNC-1];
`ifdef TT_CTRL_DEBOUNCE_EN
        bit all_i, all_e;
        si = d_inc;
        se = d_ena;
        for (int i = DEB - 1; i > 0; i--) begin
            h_inc[i] = h_inc[i-1];
            h_ena[i] = h_ena[i-1];
        end
        h_inc[0] = p_inc[SYNC-1];
        h_ena[0] = p_ena[SYNC-1];
        all_i = 1'b1;
        all_e = 1'b1;
        for (int i = 1; i < DEB; i++) begin
            if (h_inc[i] != h_inc[0]) all_i = 1'b0;
            if (h_ena[i] != h_ena[0]) all_e = 1'b0;
        end
        if (all_i) d_inc = h_inc[0];
        if (all_e) d_ena = h_ena[0];
`else
        si = p_inc[SYNC-1];
        se = p_ena[SYNC-1];
`endif
        rise = si && !m_inc_d;
        for (int k = 0; k < 2; k++) begin
            if (!sr) begin
                m_addr[k] = 0;
                m_ovf[k]  = 1'b0;
            end else if (rise && run == 0) begin
                m_addr[k] = (m_addr[k] + 1) % n_des[k];
                if (m_addr[k] == 0) m_ovf[k] = 1'b1;
            end
        end
        if (!(sr && se)) run = 0;
        else if (!(run == 0 && rise) && run <= SETTLE) run++;
        m_inc_d = si;
        for (int i = SYNC - 1; i > 0; i--) begin
            p_rst[i] = p_rst[i-1];
            p_inc[i] = p_inc[i-1];
            p_ena[i] = p_ena[i-1];
        end
        p_rst[0] = pad_sel_rst_n;
        p_inc[0] = pad_sel_inc;
        p_ena[0] = pad_ena;
    endtask

    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        if (rst_n) model_step();
    end

    always @(posedge clk) begin
        #1;
        check("addr_a", addr_a, m_addr[0]);
        check("ovf_a",  ovf_a,  m_ovf[0]);
        check("ena_a",  ena_a,  run > SETTLE);
        check("busy_a", busy_a, run <= SETTLE);
        check("addr_b", addr_b, m_addr[1]);
        check("ovf_b",  ovf_b,  m_ovf[1]);
        check("ena_b",  ena_b,  run > SETTLE);
        check("busy_b", busy_b, run <= SETTLE);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic inc_pulse();
        pad_sel_inc = 1'b1;
        cyc(PW);
        pad_sel_inc = 1'b0;
        cyc(PW);
    endtask

    task automatic sel_reset();
        pad_sel_rst_n = 1'b0;
        cyc(SYNC + 2);
        pad_sel_rst_n = 1'b1;
        cyc(SYNC + 2);
    endtask

    // Latency counted in rising edges after the negedge the stimulus was applied.
    task automatic wait_ena(input logic lvl, input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (ena_a === lvl) begin
                lat = i;
                break;
            end
        end
    endtask

    int seq[5] = '{1, 2, 3, 0, 1};
    int lat;
    logic seen;
    logic [9:0] base;

    initial begin
        model_reset();
        cyc(2);
        check("rst_addr", addr_a, 0);
        check("rst_ena",  ena_a,  0);
        check("rst_busy", busy_a, 1);
        check("rst_ovf",  ovf_a,  0);
        rst_n = 1'b1;
        cyc(4);

        // Wrap on the 4-address instance.
        sel_reset();
        for (int i = 0; i < 5; i++) begin
            inc_pulse();
            cyc(2);
            check("wrap_addr", addr_b, seq[i]);
            check("wrap_ovf",  ovf_b,  i >= 3);
        end
        sel_reset();
        check("selrst_addr", addr_b, 0);
        check("selrst_ovf",  ovf_b,  0);

        // Five increments then enable handover.
        sel_reset();
        for (int i = 0; i < 5; i++) inc_pulse();
        cyc(4);
        check("sel5_addr", addr_a, 5);
        pad_ena = 1'b1;
        wait_ena(1'b1, 60, lat);
        check("ena_rise_lat", lat, SYNC + SETTLE + 1 + DEB_LAT);
        check("ena_rise_busy", busy_a, 0);

        // Increment ignored while active; drop latency.
        pad_ena = 1'b0;
        wait_ena(1'b0, 60, lat);
        inc_pulse();
        inc_pulse();
        cyc(2);
        check("sel7_addr", addr_a, 7);
        pad_ena = 1'b1;
        wait_ena(1'b1, 60, lat);
        inc_pulse();
        cyc(4);
        check("active_addr", addr_a, 7);
        check("active_ena",  ena_a,  1);
        pad_ena = 1'b0;
        wait_ena(1'b0, 60, lat);
        check("ena_fall_lat", lat, SYNC + 1 + DEB_LAT);

`ifndef TT_CTRL_DEBOUNCE_EN
        // Abort during SETTLE.
        cyc(3);
        pad_ena = 1'b1;
        cyc(SYNC + 2);
        check("settle_busy", busy_a, 1);
        pad_ena = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            seen = seen | ena_a;
        end
        check("settle_abort", seen, 0);
`endif

        // Asynchronous reset mid-ACTIVE, then full re-arm.
        pad_ena = 1'b1;
        wait_ena(1'b1, 60, lat);
        cyc(2);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_ena",  ena_a,  0);
        check("arst_addr", addr_a, 0);
        check("arst_busy", busy_a, 1);
        cyc(2);
        rst_n = 1'b1;
        wait_ena(1'b1, 60, lat);
        check("rearm_lat", lat, SYNC + SETTLE + 1 + DEB_LAT);
        pad_ena = 1'b0;
        cyc(SYNC + DEB_LAT + 4);

`ifdef TT_CTRL_DEBOUNCE_EN
        // Glitch rejected, stable pulse accepted once.
        base = addr_a;
        pad_sel_inc = 1'b1;
        cyc(3);
        pad_sel_inc = 1'b0;
        cyc(20);
        check("deb_glitch", addr_a, base);
        pad_sel_inc = 1'b1;
        cyc(DEB);
        pad_sel_inc = 1'b0;
        cyc(25);
        check("deb_pulse", addr_a, base + 10'd1);
`endif

        // Randomised pad activity against the model.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            pad_sel_rst_n = ($urandom % 40) != 0;
            if (($urandom % 4) == 0) pad_sel_inc = ~pad_sel_inc;
            if (($urandom % 25) == 0) pad_ena = ~pad_ena;
        end
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
